// File: rtl/jb_ul_frm_mrkr_dly_gen.sv
// Per-carrier programmable frame-marker delay with pulse stretch; pulse rises T+1+frm_delay enabled cycles after marker edge T.
// No backpressure: free-running outputs; error/sticky logic present only when JB_UL_FRM_MRKR_DLY_ERR_EN is defined.
// frm_mrkr_dly_any adds one register stage on top of the per-carrier pulses.
module jb_ul_frm_mrkr_dly_gen #(
  parameter int N_CARRIERS = 1,
  parameter int CNT_BW     = 16,
  parameter int PW_BW      = 4,
  parameter int ERR_BW     = 8
) (
  input  logic                                  clk_4x,
  input  logic                                  reset_4x_n,
  input  logic [N_CARRIERS-1:0]                 clk_en,
  input  logic [N_CARRIERS-1:0]                 car_en,
  input  logic [N_CARRIERS-1:0]                 frm_mrkr_in,
  input  logic [N_CARRIERS-1:0][CNT_BW-1:0]     frm_delay,
  input  logic [N_CARRIERS-1:0][PW_BW-1:0]      pulse_width,
  input  logic                                  clear,
  output logic [N_CARRIERS-1:0]                 frm_mrkr_dly,
  output logic                                  frm_mrkr_dly_any,
  output logic [N_CARRIERS-1:0]                 armed,
  output logic [N_CARRIERS-1:0][ERR_BW-1:0]     early_err_cnt,
  output logic [N_CARRIERS-1:0][ERR_BW-1:0]     missing_err_cnt,
  output logic [N_CARRIERS-1:0]                 missing_sticky
);

  localparam logic [1:0]        ST_IDLE  = 2'd0;
  localparam logic [1:0]        ST_COUNT = 2'd1;
  localparam logic [1:0]        ST_WAIT  = 2'd2;
  localparam logic [CNT_BW-1:0] CNT_MAX  = '1;
  localparam logic [PW_BW-1:0]  PW_ONE   = PW_BW'(1);
  localparam logic [ERR_BW-1:0] ERR_MAX  = '1;

  logic any_q;

  for (genvar g = 0; g < N_CARRIERS; g++) begin : g_car
    logic [1:0]        state_q, state_d;
    logic [CNT_BW-1:0] cnt_q, cnt_d, dly_q, dly_d;
    logic [PW_BW-1:0]  pw_q, pw_d, pcnt_q, pcnt_d;
    logic              mrkr, fire, early_inc, miss_inc;

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dly_d     = dly_q;
      pw_d      = pw_q;
      pcnt_d    = (pcnt_q != '0) ? pcnt_q - 1'b1 : pcnt_q;
      fire      = 1'b0;
      early_inc = 1'b0;
      miss_inc  = 1'b0;
      mrkr      = frm_mrkr_in[g] & car_en[g];

      if (!car_en[g]) begin
        state_d = ST_IDLE;
        pcnt_d  = '0;
      end else begin
        case (state_q)
          ST_COUNT: begin
            if (clk_en[g]) begin
              if (cnt_q == dly_q) begin
                fire    = 1'b1;
                state_d = ST_WAIT;
              end
              if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            end
            early_inc = mrkr & ~fire;
          end
          ST_WAIT: begin
            // Counting on past the fire point is what detects a missing marker
            if (clk_en[g] && cnt_q != CNT_MAX) begin
              cnt_d    = cnt_q + 1'b1;
              miss_inc = (cnt_q == CNT_MAX - 1'b1) & ~mrkr;
            end
          end
          default: ;
        endcase
        if (fire) pcnt_d = pw_q;
        // A marker always restarts the frame; the aborted pulse setting is the old shadow
        if (mrkr) begin
          state_d = ST_COUNT;
          cnt_d   = '0;
          dly_d   = frm_delay[g];
          pw_d    = (pulse_width[g] == '0) ? PW_ONE : pulse_width[g];
        end
      end
    end

    always_ff @(posedge clk_4x or negedge reset_4x_n) begin
      if (!reset_4x_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        dly_q   <= '0;
        pw_q    <= '0;
        pcnt_q  <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        dly_q   <= dly_d;
        pw_q    <= pw_d;
        pcnt_q  <= pcnt_d;
      end
    end

    assign frm_mrkr_dly[g] = (pcnt_q != '0);
    assign armed[g]        = (state_q == ST_COUNT);

`ifdef JB_UL_FRM_MRKR_DLY_ERR_EN
    logic [ERR_BW-1:0] early_q, miss_q;
    logic              sticky_q;

    always_ff @(posedge clk_4x or negedge reset_4x_n) begin
      if (!reset_4x_n) begin
        early_q  <= '0;
        miss_q   <= '0;
        sticky_q <= 1'b0;
      end else if (clear) begin
        early_q  <= '0;
        miss_q   <= '0;
        sticky_q <= 1'b0;
      end else begin
        if (early_inc && early_q != ERR_MAX) early_q <= early_q + 1'b1;
        if (miss_inc && miss_q != ERR_MAX)   miss_q  <= miss_q + 1'b1;
        if (miss_inc)                        sticky_q <= 1'b1;
      end
    end

    assign early_err_cnt[g]   = early_q;
    assign missing_err_cnt[g] = miss_q;
    assign missing_sticky[g]  = sticky_q;
`else
    logic unused_err;
    assign unused_err         = early_inc | miss_inc;
    assign early_err_cnt[g]   = '0;
    assign missing_err_cnt[g] = '0;
    assign missing_sticky[g]  = 1'b0;
`endif
  end

`ifndef JB_UL_FRM_MRKR_DLY_ERR_EN
  logic unused_clear;
  logic [ERR_BW-1:0] unused_err_max;
  assign unused_clear   = clear;
  assign unused_err_max = ERR_MAX;
`endif

  always_ff @(posedge clk_4x or negedge reset_4x_n) begin
    if (!reset_4x_n) any_q <= 1'b0;
    else             any_q <= |frm_mrkr_dly;
  end

  assign frm_mrkr_dly_any = any_q;

endmodule

// File: tb/tb_jb_ul_frm_mrkr_dly_gen.sv
// Bench for jb_ul_frm_mrkr_dly_gen: directed scenarios then random traffic against a frame-level model.
module tb_jb_ul_frm_mrkr_dly_gen;
  localparam int NC = 2;
  localparam int CB = 8;
  localparam int PB = 4;
  localparam int EB = 8;
  localparam int SAT = (1 << CB) - 1;
`ifdef JB_UL_FRM_MRKR_DLY_ERR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic                    clk_4x = 1'b0;
  logic                    reset_4x_n;
  logic [NC-1:0]           clk_en, car_en, frm_mrkr_in;
  logic [NC-1:0][CB-1:0]   frm_delay;
  logic [NC-1:0][PB-1:0]   pulse_width;
  logic                    clear;
  logic [NC-1:0]           frm_mrkr_dly;
  logic                    frm_mrkr_dly_any;
  logic [NC-1:0]           armed;
  logic [NC-1:0][EB-1:0]   early_err_cnt, missing_err_cnt;
  logic [NC-1:0]           missing_sticky;

  jb_ul_frm_mrkr_dly_gen #(.N_CARRIERS(NC), .CNT_BW(CB), .PW_BW(PB), .ERR_BW(EB)) dut (
    .clk_4x(clk_4x), .reset_4x_n(reset_4x_n), .clk_en(clk_en), .car_en(car_en),
    .frm_mrkr_in(frm_mrkr_in), .frm_delay(frm_delay), .pulse_width(pulse_width), .clear(clear),
    .frm_mrkr_dly(frm_mrkr_dly), .frm_mrkr_dly_any(frm_mrkr_dly_any), .armed(armed),
    .early_err_cnt(early_err_cnt), .missing_err_cnt(missing_err_cnt), .missing_sticky(missing_sticky)
  );

  always #5 clk_4x = ~clk_4x;

  int errors = 0;
  int checks = 0;

  // Frame-level model: "seen" = enabled cycles since the last marker, "pend" = pulse owed for this frame
  int m_active[NC], m_pend[NC], m_seen[NC], m_dly[NC], m_pw[NC], m_left[NC];
  int m_early[NC], m_miss[NC], m_sticky[NC];
  int m_any;

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_active[c] = 0; m_pend[c] = 0; m_seen[c] = 0; m_dly[c] = 0; m_pw[c] = 0;
      m_left[c] = 0; m_early[c] = 0; m_miss[c] = 0; m_sticky[c] = 0;
    end
    m_any = 0;
  endfunction

  function automatic void model_step();
    int any_n;
    any_n = 0;
    for (int c = 0; c < NC; c++) if (m_left[c] > 0) any_n = 1;
    for (int c = 0; c < NC; c++) begin
      bit en, mk, fire, early, miss;
      en = clk_en[c]; mk = frm_mrkr_in[c] && car_en[c];
      fire = 0; early = 0; miss = 0;
      if (!car_en[c]) begin
        m_active[c] = 0; m_pend[c] = 0; m_left[c] = 0;
      end else begin
        fire  = m_pend[c] != 0 && en && m_seen[c] == m_dly[c];
        early = mk && m_pend[c] != 0 && !fire;
        miss  = m_active[c] != 0 && m_pend[c] == 0 && en && m_seen[c] == SAT - 1 && !mk;
        if (m_active[c] != 0 && en && m_seen[c] < SAT) m_seen[c]++;
        if (m_left[c] > 0) m_left[c]--;
        if (fire) begin m_pend[c] = 0; m_left[c] = m_pw[c]; end
        if (mk) begin
          m_active[c] = 1; m_pend[c] = 1; m_seen[c] = 0;
          m_dly[c] = int'(frm_delay[c]);
          m_pw[c] = (pulse_width[c] == 0) ? 1 : int'(pulse_width[c]);
        end
      end
      if (clear) begin
        m_early[c] = 0; m_miss[c] = 0; m_sticky[c] = 0;
      end else if (ERR_EN != 0) begin
        if (early && m_early[c] < 255) m_early[c]++;
        if (miss && m_miss[c] < 255) m_miss[c]++;
        if (miss) m_sticky[c] = 1;
      end
    end
    m_any = any_n;
  endfunction

  task automatic check_all();
    logic [NC-1:0] e_dly, e_arm, e_st;
    logic [NC-1:0][EB-1:0] e_early, e_miss;
    for (int c = 0; c < NC; c++) begin
      e_dly[c] = m_left[c] != 0; e_arm[c] = m_pend[c] != 0; e_st[c] = m_sticky[c] != 0;
      e_early[c] = m_early[c][EB-1:0]; e_miss[c] = m_miss[c][EB-1:0];
    end
    checks++;
    assert (frm_mrkr_dly === e_dly) else begin
      errors++; $error("FAIL dly_vec: observed %b expected %b at %0t", frm_mrkr_dly, e_dly, $time); end
    checks++;
    assert (frm_mrkr_dly_any === (m_any != 0)) else begin
      errors++; $error("FAIL dly_any: observed %b expected %0d at %0t", frm_mrkr_dly_any, m_any, $time); end
    checks++;
    assert (armed === e_arm) else begin
      errors++; $error("FAIL armed: observed %b expected %b at %0t", armed, e_arm, $time); end
    checks++;
    assert (early_err_cnt === e_early) else begin
      errors++; $error("FAIL early_cnt: observed %h expected %h at %0t", early_err_cnt, e_early, $time); end
    checks++;
    assert (missing_err_cnt === e_miss) else begin
      errors++; $error("FAIL miss_cnt: observed %h expected %h at %0t", missing_err_cnt, e_miss, $time); end
    checks++;
    assert (missing_sticky === e_st) else begin
      errors++; $error("FAIL sticky: observed %b expected %b at %0t", missing_sticky, e_st, $time); end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time); end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_4x);
    @(negedge clk_4x);
    check_all();
  endtask

  task automatic marker(input logic [NC-1:0] m);
    frm_mrkr_in = m;
    tick();
    frm_mrkr_in = '0;
  endtask

  initial begin
    reset_4x_n = 1'b0; clk_en = '1; car_en = '1; frm_mrkr_in = '0; clear = 1'b0;
    frm_delay = '{default: CB'(100)}; pulse_width = '{default: PB'(2)};
    model_reset();
    repeat (2) @(negedge clk_4x);
    check_all();
    chk("rst_dly", 32'(frm_mrkr_dly), 0);
    chk("rst_any", 32'(frm_mrkr_dly_any), 0);
    reset_4x_n = 1'b1;

    // Delay 100, width 2: marker at cycle 10, pulse 111-112, any 112-113
    repeat (9) tick();
    marker(2'b01);
    repeat (100) tick();
    chk("t1_pre", 32'(frm_mrkr_dly[0]), 0);
    tick(); chk("t1_111", 32'(frm_mrkr_dly[0]), 1); chk("t1_any111", 32'(frm_mrkr_dly_any), 0);
    tick(); chk("t1_112", 32'(frm_mrkr_dly[0]), 1); chk("t1_any112", 32'(frm_mrkr_dly_any), 1);
    tick(); chk("t1_113", 32'(frm_mrkr_dly[0]), 0); chk("t1_any113", 32'(frm_mrkr_dly_any), 1);
    tick(); chk("t1_any114", 32'(frm_mrkr_dly_any), 0);

    // clk_en toggling, delay 10, width 0 -> single-cycle pulse 21 after marker
    frm_delay[0] = CB'(10); pulse_width[0] = '0; clk_en[0] = 1'b0;
    marker(2'b01);
    for (int k = 1; k <= 22; k++) begin
      clk_en[0] = ~clk_en[0];
      tick();
      chk("t2_tog", 32'(frm_mrkr_dly[0]), 32'(k == 21));
    end
    clk_en = '1;

    // Delay change mid-frame is shadowed
    frm_delay[0] = CB'(50); pulse_width[0] = PB'(1);
    marker(2'b01);
    for (int k = 1; k <= 52; k++) begin
      if (k == 6) frm_delay[0] = CB'(20);
      tick();
      chk("t3_shadow", 32'(frm_mrkr_dly[0]), 32'(k == 51));
    end
    marker(2'b01);
    for (int k = 1; k <= 22; k++) begin
      tick();
      chk("t3_next", 32'(frm_mrkr_dly[0]), 32'(k == 21));
    end

    // Early marker at +30 aborts the frame
    clear = 1'b1; tick(); clear = 1'b0;
    frm_delay[0] = CB'(50);
    marker(2'b01);
    for (int k = 1; k <= 29; k++) tick();
    marker(2'b01);
    chk("t4_early", 32'(early_err_cnt[0]), 32'(ERR_EN));
    for (int k = 1; k <= 52; k++) begin
      tick();
      chk("t4_pulse", 32'(frm_mrkr_dly[0]), 32'(k == 51));
    end

    // Saturation without a second marker
    frm_delay[0] = CB'(10);
    marker(2'b01);
    repeat (254) tick();
    chk("t5_miss254", 32'(missing_err_cnt[0]), 0);
    tick();
    chk("t5_miss255", 32'(missing_err_cnt[0]), 32'(ERR_EN));
    chk("t5_sticky", 32'(missing_sticky[0]), 32'(ERR_EN));
    repeat (5) tick();
    chk("t5_once", 32'(missing_err_cnt[0]), 32'(ERR_EN));
    clear = 1'b1; tick(); clear = 1'b0;
    chk("t5_clr_cnt", 32'(missing_err_cnt[0]), 0);
    chk("t5_clr_st", 32'(missing_sticky[0]), 0);
    marker(2'b01);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("t5_recover", 32'(frm_mrkr_dly[0]), 32'(k == 11));
    end

    // Two carriers, car_en[1] dropped mid-pulse
    frm_delay[0] = CB'(5); frm_delay[1] = CB'(7); pulse_width = '{default: PB'(4)};
    marker(2'b11);
    repeat (8) tick();
    chk("t6_c1_on", 32'(frm_mrkr_dly[1]), 1);
    car_en[1] = 1'b0;
    tick();
    chk("t6_c1_off", 32'(frm_mrkr_dly[1]), 0);
    chk("t6_c0_on", 32'(frm_mrkr_dly[0]), 1);
    tick();
    chk("t6_c0_end", 32'(frm_mrkr_dly[0]), 0);
    car_en = '1;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < NC; c++) begin
        clk_en[c] = ($urandom_range(0, 3) != 0);
        car_en[c] = ($urandom_range(0, 299) != 0);
        frm_mrkr_in[c] = ($urandom_range(0, (i < 2000) ? 39 : 349) == 0);
        if ($urandom_range(0, 19) == 0) frm_delay[c] = CB'($urandom_range(0, 40));
        if ($urandom_range(0, 19) == 0) pulse_width[c] = PB'($urandom_range(0, 15));
      end
      clear = ($urandom_range(0, 499) == 0);
      tick();
    end
    clk_en = '1; car_en = '1; frm_mrkr_in = '0; clear = 1'b0;

    // Async reset while both carriers pulse
    frm_delay = '{default: CB'(30)}; pulse_width = '{default: PB'(8)};
    marker(2'b11);
    repeat (32) tick();
    chk("t8_pre", 32'(frm_mrkr_dly), 3);
    #2 reset_4x_n = 1'b0;
    #1 model_reset();
    chk("t8_dly0", 32'(frm_mrkr_dly), 0);
    chk("t8_arm0", 32'(armed), 0);
    chk("t8_any0", 32'(frm_mrkr_dly_any), 0);
    @(negedge clk_4x);
    check_all();
    reset_4x_n = 1'b1;
    repeat (40) tick();
    marker(2'b01);
    repeat (35) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
